if_stage: RTL and testbench

- Instruction-fetch stage and IF/ID pipeline register, directly upstream of the decode/control unit.
- Owns the PC and talks to instruction memory through a single-outstanding request/valid handshake.
- Presents the instruction, and its opcode field, to decode.
- Honours freeze from the control unit (multi-cycle SWP, hazards) and redirects from the branch unit.

---
 rtl/pipeline_pkg.sv | 31 +++
 rtl/if_id_reg.sv | 52 +++++
 rtl/if_stage.sv | 172 +++++++++++++++++
 tb/tb_if_stage.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: NOP encoding, opcode field layout,
// fetch-stage state encoding and opcode values shared with decode.
package pipeline_pkg;

  // Opcode field layout within a 32-bit instruction word
  localparam int OPC_W   = 6;
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;

  // All-zero word decodes as a NOP; also the pipeline bubble value
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  // Opcodes shared with the decode/control unit
  localparam logic [5:0] OPC_NOP  = 6'b000000;
  localparam logic [5:0] OPC_ALU  = 6'b000001;
  localparam logic [5:0] OPC_LOAD = 6'b000011;
  localparam logic [5:0] OPC_SWP  = 6'b111111;

  // Fetch stage states
  typedef enum logic [1:0] {
    FETCH = 2'b00,
    HOLD  = 2'b01,
    DRAIN = 2'b10
  } fetch_state_e;

  // Extract the opcode field of a 32-bit instruction
  function automatic logic [5:0] opcode_of(input logic [31:0] instr);
    return instr[OPC_MSB:OPC_LSB];
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register with flush / load / hold controls.
// Flush beats load; with neither asserted the contents hold bit-exact.
// The opcode output is a slice of the registered instruction.
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int INSTR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [ADDR_W-1:0]  d_pc,
  output logic [INSTR_W-1:0] q_instr,
  output logic [ADDR_W-1:0]  q_pc,
  output logic               q_valid,
  output logic [OPC_W-1:0]   q_opcode
);

  logic [INSTR_W-1:0] instr_r;
  logic [ADDR_W-1:0]  pc_r;
  logic               valid_r;

  // Pipeline register: bubble on flush, capture on load, otherwise hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_r <= {INSTR_W{1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
    end else if (flush) begin
      instr_r <= {INSTR_W{1'b0}};
      pc_r    <= {ADDR_W{1'b0}};
      valid_r <= 1'b0;
    end else if (load) begin
      instr_r <= d_instr;
      pc_r    <= d_pc;
      valid_r <= 1'b1;
    end else begin
      instr_r <= instr_r;
      pc_r    <= pc_r;
      valid_r <= valid_r;
    end
  end

  assign q_instr  = instr_r;
  assign q_pc     = pc_r;
  assign q_valid  = valid_r;
  assign q_opcode = instr_r[INSTR_W-1 -: OPC_W];

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, runs a single-outstanding
// request/valid handshake to instruction memory, parks a fetch that
// lands during freeze in a one-entry skid buffer, and drains a request
// that is orphaned by a branch redirect before issuing the new fetch.
module if_stage
  import pipeline_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}},
  parameter int                PC_STEP  = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               freeze,
  input  logic               branch_taken,
  input  logic [ADDR_W-1:0]  branch_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0]  if_id_pc,
  output logic               if_id_valid,
  output logic [5:0]         if_id_opcode
);

  localparam logic [ADDR_W-1:0] PC_INC = ADDR_W'(PC_STEP);

  fetch_state_e       state_r, state_s;
  logic               req_r;
  logic [ADDR_W-1:0]  pc_r, pc_s, pc_inc_s;
  logic [ADDR_W-1:0]  addr_r;
  logic [INSTR_W-1:0] skid_instr_r;
  logic [ADDR_W-1:0]  skid_pc_r;
  logic               skid_load_s, skid_clear_s;
  logic               ifid_load_s, ifid_flush_s;
  logic [INSTR_W-1:0] ifid_instr_s;
  logic [ADDR_W-1:0]  ifid_pc_s;

  // Sequential successor; wraps modulo 2^ADDR_W
  assign pc_inc_s = pc_r + PC_INC;

  // Next-state, next-PC and IF/ID / skid control decode
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    skid_load_s  = 1'b0;
    skid_clear_s = 1'b0;
    ifid_load_s  = 1'b0;
    ifid_flush_s = 1'b0;
    ifid_instr_s = imem_rdata;
    ifid_pc_s    = pc_inc_s;
    case (state_r)
      FETCH: begin
        if (branch_taken) begin
          // Redirect wins; an in-flight request with no response yet must drain
          ifid_flush_s = 1'b1;
          skid_clear_s = 1'b1;
          pc_s         = branch_addr;
          if (req_r && !imem_valid) begin
            state_s = DRAIN;
          end else begin
            state_s = FETCH;
          end
        end else if (req_r && imem_valid) begin
          pc_s = pc_inc_s;
          if (freeze) begin
            skid_load_s = 1'b1;
            state_s     = HOLD;
          end else begin
            ifid_load_s = 1'b1;
            state_s     = FETCH;
          end
        end else if (!freeze) begin
          // Nothing arrived: hand decode a bubble rather than a repeat
          ifid_flush_s = 1'b1;
        end else begin
          ifid_flush_s = 1'b0;
        end
      end
      HOLD: begin
        if (branch_taken) begin
          ifid_flush_s = 1'b1;
          skid_clear_s = 1'b1;
          pc_s         = branch_addr;
          state_s      = FETCH;
        end else if (freeze) begin
          state_s = HOLD;
        end else begin
          ifid_load_s  = 1'b1;
          ifid_instr_s = skid_instr_r;
          ifid_pc_s    = skid_pc_r;
          skid_clear_s = 1'b1;
          state_s      = FETCH;
        end
      end
      DRAIN: begin
        // IF/ID is already a bubble; the pending response is thrown away
        ifid_flush_s = 1'b1;
        if (branch_taken) begin
          pc_s = branch_addr;
        end else begin
          pc_s = pc_r;
        end
        if (imem_valid) begin
          state_s = FETCH;
        end else begin
          state_s = DRAIN;
        end
      end
      default: begin
        ifid_flush_s = 1'b1;
        skid_clear_s = 1'b1;
        state_s      = FETCH;
      end
    endcase
  end

  // FSM, PC and memory interface registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= FETCH;
      req_r   <= 1'b0;
      pc_r    <= RESET_PC;
      addr_r  <= RESET_PC;
    end else begin
      state_r <= state_s;
      req_r   <= (state_s == FETCH);
      pc_r    <= pc_s;
      // During DRAIN the bus keeps showing the address of the orphaned request
      addr_r  <= (state_s == DRAIN) ? addr_r : pc_s;
    end
  end

  // One-entry skid buffer for a fetch that completes while frozen
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_instr_r <= {INSTR_W{1'b0}};
      skid_pc_r    <= {ADDR_W{1'b0}};
    end else if (skid_clear_s) begin
      skid_instr_r <= {INSTR_W{1'b0}};
      skid_pc_r    <= {ADDR_W{1'b0}};
    end else if (skid_load_s) begin
      skid_instr_r <= imem_rdata;
      skid_pc_r    <= pc_inc_s;
    end else begin
      skid_instr_r <= skid_instr_r;
      skid_pc_r    <= skid_pc_r;
    end
  end

  assign imem_req  = req_r;
  assign imem_addr = addr_r;

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load_s),
    .flush    (ifid_flush_s),
    .d_instr  (ifid_instr_s),
    .d_pc     (ifid_pc_s),
    .q_instr  (if_id_instr),
    .q_pc     (if_id_pc),
    .q_valid  (if_id_valid),
    .q_opcode (if_id_opcode)
  );

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a latency-configurable instruction
// memory plus a transaction-level reference of the fetch stage.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        if_id_valid;
  logic [5:0]  if_id_opcode;

  if_stage dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .freeze       (freeze),
    .branch_taken (branch_taken),
    .branch_addr  (branch_addr),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .if_id_instr  (if_id_instr),
    .if_id_pc     (if_id_pc),
    .if_id_valid  (if_id_valid),
    .if_id_opcode (if_id_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Compare one observed value against the expected one
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Memory contents: opcode 1,3,5,... for words 0,1,2,... and address tag in low bits
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [5:0] op;
    op = 6'(((a >> 2) * 2) + 1);
    return {op, 2'b00, a[31:8]};
  endfunction

  // ---------------- memory model state ----------------
  logic        pending;
  int          cnt;
  int          cur_lat;
  int          lat_g;      // <0: random latency 0..3 per request
  logic [31:0] paddr;
  logic        prev_valid;

  // ---------------- reference model state ----------------
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } ent_t;
  ent_t        skid_q[$];
  logic [31:0] m_pc, m_addr, m_instr, m_ifpc;
  logic        m_valid, m_req, m_drain;

  task automatic model_reset();
    m_pc = 32'h0; m_addr = 32'h0; m_instr = 32'h0; m_ifpc = 32'h0;
    m_valid = 1'b0; m_req = 1'b0; m_drain = 1'b0;
    skid_q.delete();
    pending = 1'b0; prev_valid = 1'b0; cnt = 0; cur_lat = 0;
    imem_valid = 1'b0;
  endtask

  task automatic bubble();
    m_instr = 32'h0; m_ifpc = 32'h0; m_valid = 1'b0;
  endtask

  // One cycle of fetch-stage behaviour, written as transaction rules
  task automatic model_step(input logic fr, input logic br, input logic [31:0] ba,
                            input logic v, input logic [31:0] rd);
    logic [31:0] nxt;
    ent_t e;
    nxt = m_pc + 32'd4;
    if (br) begin
      bubble();
      skid_q.delete();
      m_drain = (m_req || m_drain) && !v;
      m_pc = ba;
    end else if (m_drain) begin
      bubble();
      if (v) m_drain = 1'b0;
    end else if (skid_q.size() != 0) begin
      if (!fr) begin
        e = skid_q.pop_front();
        m_instr = e.instr; m_ifpc = e.pc; m_valid = 1'b1;
      end
    end else if (m_req && v) begin
      if (fr) skid_q.push_back('{instr: rd, pc: nxt});
      else begin m_instr = rd; m_ifpc = nxt; m_valid = 1'b1; end
      m_pc = nxt;
    end else if (!fr) begin
      bubble();
    end
    m_req = !m_drain && (skid_q.size() == 0);
    if (!m_drain) m_addr = m_pc;
  endtask

  task automatic check_outputs();
    check("imem_req", imem_req, m_req);
    if (m_req || m_drain) check("imem_addr", imem_addr, m_addr);
    check("if_id_valid", if_id_valid, m_valid);
    check("if_id_instr", if_id_instr, m_instr);
    check("if_id_pc", if_id_pc, m_ifpc);
    check("if_id_opcode", if_id_opcode, m_instr[31:26]);
  endtask

  task automatic check_reset();
    check("rst_imem_req", imem_req, 1'b0);
    check("rst_imem_addr", imem_addr, 32'h0);
    check("rst_if_id_instr", if_id_instr, 32'h0);
    check("rst_if_id_pc", if_id_pc, 32'h0);
    check("rst_if_id_valid", if_id_valid, 1'b0);
  endtask

  // Entered just after a rising edge: drive one cycle, advance, then check
  task automatic one_cycle(input logic fr, input logic br, input logic [31:0] ba);
    if (prev_valid) pending = 1'b0;
    else if (pending) cnt++;
    if (!pending && imem_req === 1'b1) begin
      pending = 1'b1; cnt = 0; paddr = imem_addr;
      cur_lat = (lat_g < 0) ? $urandom_range(0, 3) : lat_g;
    end
    imem_valid = pending && (cnt >= cur_lat);
    imem_rdata = imem_valid ? mem_word(paddr) : $urandom;
    prev_valid = imem_valid;
    freeze = fr; branch_taken = br; branch_addr = ba;
    model_step(fr, br, ba, imem_valid, imem_rdata);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  // Asynchronous reset pulse between edges, released on the falling edge
  task automatic do_reset();
    rst_n = 1'b0;
    freeze = 1'b0; branch_taken = 1'b0; imem_valid = 1'b0;
    #1;
    check_reset();
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; freeze = 1'b0; branch_taken = 1'b0; branch_addr = 32'h0;
    imem_rdata = 32'h0; lat_g = 0; paddr = 32'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Zero-wait streaming from reset
    lat_g = 0;
    repeat (3) one_cycle(1'b0, 1'b0, 32'h0);
    check("stream_pc", if_id_pc, 32'h8);
    check("stream_opcode", if_id_opcode, 6'b000011);
    repeat (5) one_cycle(1'b0, 1'b0, 32'h0);

    // Two-cycle latency
    lat_g = 2;
    repeat (12) one_cycle(1'b0, 1'b0, 32'h0);

    // Freeze over an SWP-opcode instruction while the next fetch lands
    lat_g = 0;
    one_cycle(1'b0, 1'b1, 32'h7C);
    one_cycle(1'b0, 1'b0, 32'h0);
    check("swp_opcode", if_id_opcode, 6'b111111);
    one_cycle(1'b1, 1'b0, 32'h0);
    check("frz1_opcode", if_id_opcode, 6'b111111);
    check("frz1_req", imem_req, 1'b0);
    one_cycle(1'b1, 1'b0, 32'h0);
    check("frz2_pc", if_id_pc, 32'h80);
    one_cycle(1'b0, 1'b0, 32'h0);
    check("unfrz_pc", if_id_pc, 32'h84);
    check("unfrz_addr", imem_addr, 32'h84);

    // Branch while a 3-cycle request to 0x10 is outstanding
    do_reset();
    lat_g = 0;
    for (int i = 0; i < 10 && imem_addr !== 32'h10; i++) one_cycle(1'b0, 1'b0, 32'h0);
    check("reach_0x10", imem_addr, 32'h10);
    lat_g = 3;
    one_cycle(1'b0, 1'b0, 32'h0);
    one_cycle(1'b0, 1'b1, 32'h40);
    check("br_bubble_valid", if_id_valid, 1'b0);
    check("br_bubble_instr", if_id_instr, 32'h0);
    lat_g = 0;
    for (int i = 0; i < 10 && imem_req !== 1'b1; i++) one_cycle(1'b0, 1'b0, 32'h0);
    check("drain_next_addr", imem_addr, 32'h40);

    // Branch coincident with freeze and a returning fetch
    one_cycle(1'b0, 1'b0, 32'h0);
    one_cycle(1'b1, 1'b1, 32'h80);
    check("brfrz_valid", if_id_valid, 1'b0);
    check("brfrz_addr", imem_addr, 32'h80);
    one_cycle(1'b0, 1'b0, 32'h0);
    check("brfrz_next_pc", if_id_pc, 32'h84);

    // PC wrap at the top of the address space
    one_cycle(1'b0, 1'b1, 32'hFFFF_FFFC);
    one_cycle(1'b0, 1'b0, 32'h0);
    check("wrap_if_id_pc", if_id_pc, 32'h0);
    check("wrap_imem_addr", imem_addr, 32'h0);

    // Reset mid-request at PC 0x20
    lat_g = 3;
    do_reset();
    for (int i = 0; i < 60 && !(imem_addr === 32'h20 && imem_req === 1'b1); i++)
      one_cycle(1'b0, 1'b0, 32'h0);
    check("reach_0x20", imem_addr, 32'h20);
    one_cycle(1'b0, 1'b0, 32'h0);
    do_reset();
    one_cycle(1'b0, 1'b0, 32'h0);
    check("restart_addr", imem_addr, 32'h0);

    // Randomised traffic: latency, freeze, redirects and occasional resets
    lat_g = -1;
    for (int i = 0; i < 600; i++) begin
      logic        fr, br;
      logic [31:0] ba;
      fr = ($urandom_range(0, 99) < 30);
      br = ($urandom_range(0, 99) < 8);
      ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC))
                                       : ($urandom & 32'h0000_0FFC);
      if ($urandom_range(0, 199) == 0) do_reset();
      one_cycle(fr, br, ba);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
